// File: rtl/calc_alu_seq_if.sv
// Operand/result bus for calc_alu_seq.
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high; the sender holds its payload stable from raising valid until that
// edge, and ready may not depend combinationally on valid.
interface calc_alu_seq_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero, acc
  );

  modport slave (
    input  in_valid, op, a, b, acc_clr, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero, acc
  );
endinterface

// File: rtl/calc_alu_seq.sv
// Registered add/sub/accumulate/multiply unit. ADD/SUB/ACC complete on the
// transfer edge; MUL is a WIDTH-cycle shift-add. Results and flags are held
// in DONE until the consumer takes them.
module calc_alu_seq #(
  parameter int WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  calc_alu_seq_if.slave       bus,
  output logic [1:0]          dbg_state
);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   result_r;
  logic               carry_r;
  logic               ovf_r;
  logic               zero_r;
  logic [WIDTH-1:0]   acc_r;

  logic               accept;
  logic               mul_last;
  logic [WIDTH-1:0]   acc_base;
  logic [WIDTH:0]     alu_sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  assign accept   = bus.in_valid && (state == S_IDLE);
  assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));

  // Single-cycle ALU for ADD/SUB/ACC; a clear coinciding with ACC adds onto zero.
  always_comb begin
    acc_base  = bus.acc_clr ? '0 : acc_r;
    alu_sum   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        alu_carry = alu_sum[WIDTH];
        alu_ovf   = (bus.a[MSB] == bus.b[MSB]) && (alu_sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_sum   = {1'b0, bus.a} - {1'b0, bus.b};
        alu_carry = alu_sum[WIDTH];
        alu_ovf   = (bus.a[MSB] != bus.b[MSB]) && (alu_sum[MSB] != bus.a[MSB]);
      end
      OP_ACC: begin
        alu_sum   = {1'b0, acc_base} + {1'b0, bus.a};
        alu_carry = alu_sum[WIDTH];
        alu_ovf   = (acc_base[MSB] == bus.a[MSB]) && (alu_sum[MSB] != acc_base[MSB]);
      end
      default: begin
        alu_sum   = '0;
      end
    endcase
    alu_res = alu_sum[WIDTH-1:0];
  end

  // Partial product after this cycle's conditional add.
  always_comb begin
    product_next = product + (mplier[0] ? mcand : '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = (bus.op == OP_MUL) ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (mul_last) state_next = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Multiplier iteration and result/flag capture; results change only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      product  <= '0;
      cnt      <= '0;
      result_r <= '0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else if (accept) begin
      if (bus.op == OP_MUL) begin
        mcand   <= {{WIDTH{1'b0}}, bus.a};
        mplier  <= bus.b;
        product <= '0;
        cnt     <= '0;
      end else begin
        result_r <= alu_res;
        carry_r  <= alu_carry;
        ovf_r    <= alu_ovf;
        zero_r   <= (alu_res == '0);
      end
    end else if (state == S_MUL) begin
      product <= product_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + CW'(1);
      if (mul_last) begin
        result_r <= product_next[WIDTH-1:0];
        carry_r  <= |product_next[2*WIDTH-1:WIDTH];
        ovf_r    <= |product_next[2*WIDTH-1:WIDTH];
        zero_r   <= (product_next[WIDTH-1:0] == '0);
      end
    end
  end

  // Accumulator: an accepted ACC writes its sum, otherwise acc_clr zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             acc_r <= '0;
    else if (accept && (bus.op == OP_ACC))  acc_r <= alu_res;
    else if (bus.acc_clr)                   acc_r <= '0;
  end

  assign bus.result = result_r;
  assign bus.carry  = carry_r;
  assign bus.ovf    = ovf_r;
  assign bus.zero   = zero_r;
  assign bus.acc    = acc_r;
  assign dbg_state  = state;
endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed plus random bench for calc_alu_seq at WIDTH=6.
module tb_calc_alu_seq;
  localparam int W = 6;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  calc_alu_seq_if #(.WIDTH(W)) bus ();

  calc_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+2:0] exp_q[$];
  longint m_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic longint to_signed(input longint u);
    return (u >= (64'sd1 << (W - 1))) ? u - (64'sd1 << W) : u;
  endfunction

  // Reference: integer arithmetic, returns {result, carry, ovf, zero}.
  task automatic model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic clr, output logic [W+2:0] res);
    longint ua, ub, mod, s, r, sr, smax, smin;
    logic c, ov;
    ua = longint'(av); ub = longint'(bv);
    mod = 64'sd1 << W;
    smax = (64'sd1 << (W - 1)) - 1;
    smin = -(64'sd1 << (W - 1));
    c = 1'b0; ov = 1'b0; r = 0;
    case (o)
      OP_ADD: begin
        s = ua + ub; r = s % mod; c = (s >= mod);
        sr = to_signed(ua) + to_signed(ub); ov = (sr > smax) || (sr < smin);
      end
      OP_SUB: begin
        s = ua - ub; r = (s + mod) % mod; c = (ua < ub);
        sr = to_signed(ua) - to_signed(ub); ov = (sr > smax) || (sr < smin);
      end
      OP_ACC: begin
        if (clr) m_acc = 0;
        s = m_acc + ua; r = s % mod; c = (s >= mod);
        sr = to_signed(m_acc) + to_signed(ua); ov = (sr > smax) || (sr < smin);
        m_acc = r;
      end
      default: begin
        s = ua * ub; r = s % mod; c = ((s / mod) != 0); ov = c;
      end
    endcase
    if (clr && o != OP_ACC) m_acc = 0;
    res = {r[W-1:0], c, ov, (r == 0)};
  endtask

  // Driver: one operation through both handshakes, optional backpressure.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic clr, input int hold, input bit clr_in_hold);
    int lat;
    int t;
    logic [W+2:0] exp_v;
    logic [W+2:0] got;
    logic pulsed;
    t = 0;
    while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.a         = av;
    bus.b         = bv;
    bus.acc_clr   = clr;
    bus.out_ready = (hold == 0);
    model(o, av, bv, clr, exp_v);
    exp_q.push_back(exp_v);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.op       = 2'($urandom_range(0, 3));
        bus.a        = W'($urandom_range(0, 63));
        bus.b        = W'($urandom_range(0, 63));
      end
      if (!bus.out_valid) check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    end while (!bus.out_valid && lat < 40);
    check("latency", 32'(lat), (o == OP_MUL) ? 32'(W + 1) : 32'd1);
    got = {bus.result, bus.carry, bus.ovf, bus.zero};
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      exp_v = exp_q.pop_front();
      check("result_flags", 32'(got), 32'(exp_v));
    end
    check("acc", 32'(bus.acc), 32'(m_acc));
    for (int i = 0; i < hold; i++) begin
      pulsed = clr_in_hold && (i == 1);
      bus.acc_clr = pulsed;
      @(negedge clk);
      bus.acc_clr = 1'b0;
      if (pulsed) m_acc = 0;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_result", 32'({bus.result, bus.carry, bus.ovf, bus.zero}), 32'(exp_v));
      check("hold_acc", 32'(bus.acc), 32'(m_acc));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_res_flags"}, 32'({bus.result, bus.carry, bus.ovf, bus.zero}), 32'd0);
    check({tag, "_acc"}, 32'(bus.acc), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Directed sequence, then random traffic, then report.
  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_ADD, 6'h02, 6'h03, 1'b0, 0, 1'b0);
    run_op(OP_ADD, 6'h1F, 6'h01, 1'b0, 0, 1'b0);
    run_op(OP_ADD, 6'h3F, 6'h01, 1'b0, 0, 1'b0);
    run_op(OP_SUB, 6'h06, 6'h03, 1'b0, 0, 1'b0);
    run_op(OP_SUB, 6'h04, 6'h07, 1'b0, 0, 1'b0);
    run_op(OP_SUB, 6'h20, 6'h01, 1'b0, 0, 1'b0);
    run_op(OP_SUB, 6'h09, 6'h09, 1'b0, 0, 1'b0);
    run_op(OP_MUL, 6'h07, 6'h09, 1'b0, 0, 1'b0);
    run_op(OP_MUL, 6'h0F, 6'h0E, 1'b0, 0, 1'b0);

    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    m_acc = 0;
    check("acc_clr_idle", 32'(bus.acc), 32'd0);
    run_op(OP_ACC, 6'h05, 6'h2A, 1'b0, 0, 1'b0);
    run_op(OP_ACC, 6'h0A, 6'h15, 1'b0, 0, 1'b0);
    run_op(OP_ACC, 6'h30, 6'h00, 1'b0, 0, 1'b0);
    run_op(OP_ACC, 6'h01, 6'h3F, 1'b0, 0, 1'b0);
    run_op(OP_ACC, 6'h07, 6'h00, 1'b0, 0, 1'b0);
    run_op(OP_ACC, 6'h04, 6'h00, 1'b1, 0, 1'b0);

    run_op(OP_ADD, 6'h04, 6'h07, 1'b0, 5, 1'b1);

    // Asynchronous reset three cycles into a multiply.
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.a        = 6'h0F;
    bus.b        = 6'h0E;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mul_state", 32'(dbg_state), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_acc = 0;
    check_reset_values("mid_mul_reset");
    repeat (2) begin
      @(negedge clk);
      check("reset_no_valid", 32'(bus.out_valid), 32'd0);
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("post_reset_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op(OP_ADD, 6'h01, 6'h01, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom_range(0, 63)), W'($urandom_range(0, 63)),
             1'($urandom_range(0, 7) == 0), $urandom_range(0, 2), 1'b0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
